// File: rtl/discharge_param_sequencer_if.sv
// Parameter-table configuration bus of the discharge parameter sequencer.
// The master side (host / register block) writes one slot per strobe.
interface discharge_param_sequencer_if #(
    parameter int SLOT_AW = 2
);
    logic               cfg_wr_en;
    logic [SLOT_AW-1:0] cfg_addr;
    logic [15:0]        cfg_wave;
    logic [15:0]        cfg_ton;
    logic [15:0]        cfg_ts;
    logic [7:0]         cfg_ict;
    logic [15:0]        cfg_repeat;

    modport master (
        output cfg_wr_en, cfg_addr, cfg_wave, cfg_ton, cfg_ts, cfg_ict, cfg_repeat
    );

    modport slave (
        input cfg_wr_en, cfg_addr, cfg_wave, cfg_ton, cfg_ts, cfg_ict, cfg_repeat
    );
endinterface

// File: rtl/discharge_param_sequencer.sv
// Discharge parameter sequencer: steps a small table of parameter sets into
// mos_control, advancing only at pulse boundaries (DEION) so a discharge
// never sees its parameters change. Supports graceful stop, fault abort and
// one-shot runs, and counts effective and open pulses.
module discharge_param_sequencer #(
    parameter int         SLOT_AW       = 2,
    parameter logic [7:0] ST_WAIT_BD    = 8'h01,
    parameter logic [7:0] ST_DEION      = 8'h80,
    parameter logic [7:0] ST_DISCH_MASK = 8'h1E
) (
    input  logic                       clk,
    input  logic                       rst_n,
    discharge_param_sequencer_if.slave cfg,
    input  logic [SLOT_AW:0]           seq_len,
    input  logic                       one_shot,
    input  logic                       seq_start,
    input  logic                       seq_stop,
    input  logic                       fault,
    input  logic [7:0]                 mos_state,
    output logic [15:0]                waveform_data,
    output logic [15:0]                ton,
    output logic [15:0]                ts,
    output logic [7:0]                 inductor_charging_time,
    output logic                       is_machine_start,
    output logic                       busy,
    output logic [SLOT_AW-1:0]         active_slot,
    output logic [31:0]                pulse_cnt,
    output logic [15:0]                open_cnt,
    output logic                       seq_done,
    output logic                       fault_flag
);

    localparam int                 NUM_SLOTS   = 2 ** SLOT_AW;
    localparam logic [SLOT_AW:0]   NUM_SLOTS_W = (SLOT_AW + 1)'(NUM_SLOTS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_RUN      = 2'd2,
        S_STOPPING = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [15:0]        wave_tab_r [NUM_SLOTS];
    logic [15:0]        ton_tab_r  [NUM_SLOTS];
    logic [15:0]        ts_tab_r   [NUM_SLOTS];
    logic [7:0]         ict_tab_r  [NUM_SLOTS];
    logic [15:0]        rep_tab_r  [NUM_SLOTS];

    logic [7:0]         prev_state_r;
    logic               eff_pulse_r;
    logic               open_pulse_r;
    logic [15:0]        slot_pulse_r;

    logic [SLOT_AW-1:0] last_slot_s;
    logic [SLOT_AW-1:0] next_slot_s;
    logic [15:0]        rep_s;
    logic [15:0]        slot_pulse_inc_s;
    logic               rep_hit_s;
    logic               is_last_s;
    logic               deion_s;

    logic               load_s;
    logic [SLOT_AW-1:0] load_slot_s;
    logic               clr_cnt_s;
    logic               ims_s;
    logic               done_s;
    logic               flag_s;
    logic [15:0]        slot_pulse_s;

    assign deion_s          = (mos_state == ST_DEION);
    assign rep_s            = rep_tab_r[active_slot];
    assign slot_pulse_inc_s = slot_pulse_r + 16'd1;
    assign rep_hit_s        = (rep_s != 16'd0) && (slot_pulse_inc_s == rep_s);
    assign is_last_s        = (active_slot == last_slot_s);
    assign next_slot_s      = is_last_s ? {SLOT_AW{1'b0}} : active_slot + SLOT_AW'(1'b1);

    // Effective last slot index: seq_len of 0 acts as 1, oversize values clamp.
    always_comb begin
        if (seq_len == {(SLOT_AW + 1){1'b0}}) begin
            last_slot_s = {SLOT_AW{1'b0}};
        end else if (seq_len > NUM_SLOTS_W) begin
            last_slot_s = {SLOT_AW{1'b1}};
        end else begin
            last_slot_s = seq_len[SLOT_AW-1:0] - SLOT_AW'(1'b1);
        end
    end

    // Next-state and control decisions; fault overrides everything.
    always_comb begin
        state_s      = state_r;
        load_s       = 1'b0;
        load_slot_s  = {SLOT_AW{1'b0}};
        clr_cnt_s    = 1'b0;
        ims_s        = is_machine_start;
        done_s       = 1'b0;
        flag_s       = fault_flag;
        slot_pulse_s = slot_pulse_r;
        if (fault) begin
            state_s = S_IDLE;
            ims_s   = 1'b0;
            flag_s  = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ims_s = 1'b0;
                    if (seq_start && !seq_stop) begin
                        state_s      = S_LOAD;
                        load_s       = 1'b1;
                        clr_cnt_s    = 1'b1;
                        flag_s       = 1'b0;
                        slot_pulse_s = 16'd0;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_LOAD: begin
                    state_s = S_RUN;
                    ims_s   = 1'b1;
                end
                S_RUN: begin
                    ims_s = 1'b1;
                    if (seq_stop) begin
                        if (deion_s) begin
                            state_s = S_IDLE;
                            ims_s   = 1'b0;
                        end else begin
                            state_s = S_STOPPING;
                        end
                    end else if (eff_pulse_r) begin
                        if (rep_hit_s) begin
                            slot_pulse_s = 16'd0;
                            if (is_last_s && one_shot) begin
                                state_s = S_IDLE;
                                ims_s   = 1'b0;
                                done_s  = 1'b1;
                            end else begin
                                load_s      = 1'b1;
                                load_slot_s = next_slot_s;
                            end
                        end else begin
                            slot_pulse_s = slot_pulse_inc_s;
                        end
                    end else begin
                        state_s = S_RUN;
                    end
                end
                S_STOPPING: begin
                    ims_s = 1'b1;
                    if (deion_s) begin
                        state_s = S_IDLE;
                        ims_s   = 1'b0;
                    end else begin
                        state_s = S_STOPPING;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    ims_s   = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Parameter table; writes never touch the live outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                wave_tab_r[i] <= 16'd0;
                ton_tab_r[i]  <= 16'd0;
                ts_tab_r[i]   <= 16'd0;
                ict_tab_r[i]  <= 8'd0;
                rep_tab_r[i]  <= 16'd0;
            end
        end else if (cfg.cfg_wr_en) begin
            wave_tab_r[cfg.cfg_addr] <= cfg.cfg_wave;
            ton_tab_r[cfg.cfg_addr]  <= cfg.cfg_ton;
            ts_tab_r[cfg.cfg_addr]   <= cfg.cfg_ts;
            ict_tab_r[cfg.cfg_addr]  <= cfg.cfg_ict;
            rep_tab_r[cfg.cfg_addr]  <= cfg.cfg_repeat;
        end
    end

    // Pulse-end detection from the mos_control state trace (one-cycle events).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_r <= 8'h00;
            eff_pulse_r  <= 1'b0;
            open_pulse_r <= 1'b0;
        end else begin
            prev_state_r <= mos_state;
            eff_pulse_r  <= deion_s && ((prev_state_r & ST_DISCH_MASK) != 8'h00);
            open_pulse_r <= deion_s && (prev_state_r == ST_WAIT_BD);
        end
    end

    // Saturating pulse counters; events are counted in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt <= 32'd0;
            open_cnt  <= 16'd0;
        end else if (clr_cnt_s) begin
            pulse_cnt <= 32'd0;
            open_cnt  <= 16'd0;
        end else begin
            if (eff_pulse_r && (pulse_cnt != 32'hFFFF_FFFF)) begin
                pulse_cnt <= pulse_cnt + 32'd1;
            end
            if (open_pulse_r && (open_cnt != 16'hFFFF)) begin
                open_cnt <= open_cnt + 16'd1;
            end
        end
    end

    // Registered control outputs and the live parameter set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_machine_start       <= 1'b0;
            busy                   <= 1'b0;
            seq_done               <= 1'b0;
            fault_flag             <= 1'b0;
            slot_pulse_r           <= 16'd0;
            active_slot            <= {SLOT_AW{1'b0}};
            waveform_data          <= 16'd0;
            ton                    <= 16'd0;
            ts                     <= 16'd0;
            inductor_charging_time <= 8'd0;
        end else begin
            is_machine_start <= ims_s;
            busy             <= (state_s != S_IDLE);
            seq_done         <= done_s;
            fault_flag       <= flag_s;
            slot_pulse_r     <= slot_pulse_s;
            if (load_s) begin
                active_slot            <= load_slot_s;
                waveform_data          <= wave_tab_r[load_slot_s];
                ton                    <= ton_tab_r[load_slot_s];
                ts                     <= ts_tab_r[load_slot_s];
                inductor_charging_time <= ict_tab_r[load_slot_s];
            end
        end
    end

endmodule

// File: doc/discharge_param_sequencer.md
Name: discharge_param_sequencer

Overview:
- Sequences discharge parameters into the pulse generator (mos_control).
- Holds a small table of parameter sets (slots) and drives waveform_data, Ton, Ts, inductor_charging_time and is_machine_start into mos_control.
- Monitors mos_control current_state to count effective and open pulses. Advances slots only at pulse boundaries, so parameters never change mid-discharge.
- Handles graceful stop, immediate fault abort and one-shot runs.

Parameters:
- SLOT_AW, 2, slot address width; NUM_SLOTS = 2**SLOT_AW.
- ST_WAIT_BD, 8'h01, mos_control wait-breakdown state code.
- ST_DEION, 8'h80, mos_control deionisation state code.
- ST_DISCH_MASK, 8'h1E, state bits that count as active discharge (rect rise, rect interleave, sawtooth, resistor).

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr_en  in  1  table write strobe
- cfg_addr  in  SLOT_AW  slot index
- cfg_wave  in  16  waveform code for slot
- cfg_ton  in  16  Ton for slot
- cfg_ts  in  16  Ts for slot
- cfg_ict  in  8  inductor charging time for slot
- cfg_repeat  in  16  effective pulses per slot; 0 = hold slot indefinitely
- seq_len  in  SLOT_AW+1  active slots; 0 is treated as 1; values above NUM_SLOTS are clamped
- one_shot  in  1  1 = stop after last slot completes; 0 = wrap to slot 0
- seq_start  in  1  start pulse
- seq_stop  in  1  graceful stop pulse
- fault  in  1  immediate abort (level)
- mos_state  in  8  mos_control current_state
- waveform_data  out  16  to mos_control
- ton  out  16  to mos_control
- ts  out  16  to mos_control
- inductor_charging_time  out  8  to mos_control
- is_machine_start  out  1  to mos_control
- busy  out  1  FSM not in IDLE
- active_slot  out  SLOT_AW  slot currently driven
- pulse_cnt  out  32  effective pulses since start, saturating
- open_cnt  out  16  open (no-breakdown) pulses since start, saturating
- seq_done  out  1  one-cycle pulse at one-shot completion
- fault_flag  out  1  sticky; cleared by seq_start

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM state IDLE; table contents 0 with repeat 0.
- Table writes: accepted in any state, one per cycle. A write to the active slot takes effect only at the next reload of that slot; live outputs are never modified by a write.
- Event detection: prev_state is registered from mos_state.
  - eff_pulse: mos_state==ST_DEION and prev_state&ST_DISCH_MASK != 0.
  - open_pulse: mos_state==ST_DEION and prev_state==ST_WAIT_BD.
  - Each event is one cycle wide and appears one cycle after mos_control enters DEION.
- FSM states: IDLE, LOAD, RUN, STOPPING.
- IDLE:
  - is_machine_start=0.
  - seq_start (with fault low) → LOAD; fault_flag, pulse_cnt, open_cnt and slot_pulse count are cleared.
- LOAD:
  - Copies slot 0 into the four parameter outputs; active_slot=0 → RUN.
  - Latency: seq_start in cycle N; parameters valid at N+1; is_machine_start=1 at N+2.
- RUN:
  - is_machine_start=1.
  - eff_pulse: increment pulse_cnt (saturates at 2^32-1) and slot_pulse.
    - If cfg_repeat[active_slot]!=0 and slot_pulse+1==repeat, clear slot_pulse.
    - Last active slot with one_shot=1: → IDLE, is_machine_start=0 next cycle, seq_done=1 for one cycle.
    - Otherwise reload outputs from the next slot (wrapping to 0) on the next cycle. mos_control is in DEION at that point.
  - open_pulse: increment open_cnt (saturates at 16'hFFFF); does not count toward repeat.
- seq_stop in RUN:
  - If mos_state==ST_DEION: → IDLE, is_machine_start dropped next cycle.
  - Otherwise → STOPPING.
- STOPPING:
  - Hold is_machine_start=1 and parameters until mos_state==ST_DEION, then → IDLE.
  - Events occurring in STOPPING are still counted; no slot advance.
- Fault handling: fault high in any state → IDLE next cycle, is_machine_start=0, fault_flag=1. Fault has priority over all other inputs.
- Simultaneous inputs:
  - seq_start together with seq_stop: stop wins, and start is ignored.
  - seq_start in a non-IDLE state is ignored.
  - seq_start while fault is high is ignored.
- Parameter outputs hold their last values in IDLE; only LOAD or a slot advance changes them.
- Arithmetic: slot_pulse is 16-bit, compared unsigned. Slot wrap is computed against the effective seq_len.
- Mid-operation reset: immediate return to reset values, including is_machine_start=0.

Test Plan:
- Basic start: slot0={wave 0, ton 500, ts 2000, ict 40, rep 3}, seq_len=1; pulse seq_start → outputs loaded at N+1, is_machine_start=1 at N+2, busy=1.
- Slot advance: seq_len=2, slot0 rep 2, slot1 ton 800; drive mos_state 01→04→80 twice → ton=800 and active_slot=1 one cycle after the 2nd eff_pulse. Add 3 open pulses (01→80) → open_cnt=3, slot unchanged.
- One-shot: seq_len=2, one_shot=1, both slots rep 1; two effective pulses → seq_done single pulse, is_machine_start=0, busy=0, pulse_cnt=2.
- Graceful stop: seq_stop while mos_state=04 → is_machine_start stays 1; mos_state→80 → is_machine_start=0 next cycle, busy=0.
- Fault and start/stop collision: fault high in RUN → is_machine_start=0 next cycle, fault_flag=1. Then seq_start with fault low → fault_flag clears. seq_start and seq_stop in the same cycle in IDLE → remains IDLE.
- Table write during RUN to active slot 0 (ton 900): ton unchanged until slot 0 is reloaded after wrap; rep=0 → slot never advances after 100 effective pulses.
